// File: rtl/mm_timer_pkg.sv
// mm_timer_pkg: register map, bit positions and handshake states
// shared by the timer peripheral and its prescaler.
package mm_timer_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_LOAD   = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQEN      = 2;
    localparam int STATUS_EXPIRED  = 0;

    typedef enum logic [1:0] {
        IDLE,
        RD_ACK,
        WR_ACK
    } hsState_e;

endpackage

// File: rtl/mm_timer_peripheral_if.sv
// MMPeripheralInterface: four-phase memory-mapped bus between the
// memory controller and its responders.
interface MMPeripheralInterface;

    logic [31:0] AddressBus;
    logic [31:0] DataWriteBus;
    logic [31:0] DataReadBus;
    logic        ReadAssert;
    logic        WriteAssert;
    logic        ReadOK;
    logic        WriteOK;

    modport Controller (
        output AddressBus,
        output DataWriteBus,
        output ReadAssert,
        output WriteAssert,
        input  DataReadBus,
        input  ReadOK,
        input  WriteOK
    );

    modport Peripheral (
        input  AddressBus,
        input  DataWriteBus,
        input  ReadAssert,
        input  WriteAssert,
        output DataReadBus,
        output ReadOK,
        output WriteOK
    );

endinterface

// File: rtl/mm_timer_prescaler.sv
// mm_timer_prescaler: divides the core clock into counter ticks;
// held in its first phase whenever the timer is disabled.
module mm_timer_prescaler #(
    parameter int PRESCALE_DIV = 1
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic Enable,
    output logic Tick
);

    localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE_DIV - 1);

    logic [PW-1:0] phase;

    assign Tick = Enable && (phase == LAST);

    always_ff @(posedge Clock) begin
        if (!Reset_n || !Enable) begin
            phase <= '0;
        end else if (Tick) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

endmodule

// File: rtl/mm_timer_peripheral.sv
// mm_timer_peripheral: bus responder in front of a prescaled down-counter.
// Define MMTIMER_IRQ_EN to add the registered Irq output.
module mm_timer_peripheral
    import mm_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_1000,
    parameter int          COUNTER_WIDTH = 32,
    parameter int          PRESCALE_DIV  = 1
) (
    input  logic Clock,
    input  logic Reset_n,
    MMPeripheralInterface.Peripheral Bus
`ifdef MMTIMER_IRQ_EN
    ,
    output logic Irq
`endif
);

    localparam int CW = COUNTER_WIDTH;

    hsState_e state;
    hsState_e stateNext;

    logic          select;
    logic [1:0]    offset;
    logic          wrEn;
    logic          rdEn;
    logic          tick;
    logic [2:0]    ctrl;
    logic [CW-1:0] load;
    logic [CW-1:0] count;
    logic          expired;
    logic [31:0]   readMux;
    logic [31:0]   readBuf;
    logic          unusedBits;

    assign select = Bus.AddressBus[31:4] == BASE_ADDR[31:4];
    assign offset = Bus.AddressBus[3:2];
    assign unusedBits = ^{Bus.AddressBus[1:0], Bus.DataWriteBus};

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Accesses are only accepted from IDLE; ack states ignore the address.
    always_comb begin
        stateNext = state;
        wrEn      = 1'b0;
        rdEn      = 1'b0;
        unique case (state)
            IDLE: begin
                if (select && Bus.WriteAssert) begin
                    wrEn      = 1'b1;
                    stateNext = WR_ACK;
                end else if (select && Bus.ReadAssert) begin
                    rdEn      = 1'b1;
                    stateNext = RD_ACK;
                end
            end
            RD_ACK: if (!Bus.ReadAssert) stateNext = IDLE;
            WR_ACK: if (!Bus.WriteAssert) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign Bus.ReadOK      = state == RD_ACK;
    assign Bus.WriteOK     = state == WR_ACK;
    assign Bus.DataReadBus = (state == RD_ACK) ? readBuf : '0;

    always_comb begin
        readMux = '0;
        unique case (offset)
            OFF_CTRL:   readMux = {29'd0, ctrl};
            OFF_LOAD:   readMux = 32'(load);
            OFF_COUNT:  readMux = 32'(count);
            OFF_STATUS: readMux = {31'd0, expired};
            default:    readMux = '0;
        endcase
    end

    mm_timer_prescaler #(
        .PRESCALE_DIV(PRESCALE_DIV)
    ) uPrescaler (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .Enable (ctrl[CTRL_ENABLE]),
        .Tick   (tick)
    );

    // Later assignments win: expiry over STATUS clear, bus over timer.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            readBuf <= '0;
            ctrl    <= '0;
            load    <= '0;
            count   <= '0;
            expired <= 1'b0;
        end else begin
            if (rdEn) readBuf <= readMux;
            if (wrEn && offset == OFF_STATUS
                && Bus.DataWriteBus[STATUS_EXPIRED]) begin
                expired <= 1'b0;
            end
            if (tick) begin
                if (count != '0) begin
                    count <= count - CW'(1);
                end else begin
                    expired <= 1'b1;
                    if (ctrl[CTRL_AUTORELOAD]) begin
                        count <= load;
                    end else begin
                        ctrl[CTRL_ENABLE] <= 1'b0;
                    end
                end
            end
            if (wrEn && offset == OFF_CTRL) begin
                ctrl <= Bus.DataWriteBus[2:0];
            end
            if (wrEn && offset == OFF_LOAD) begin
                load  <= Bus.DataWriteBus[CW-1:0];
                count <= Bus.DataWriteBus[CW-1:0];
            end
        end
    end

`ifdef MMTIMER_IRQ_EN
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            Irq <= 1'b0;
        end else begin
            Irq <= expired & ctrl[CTRL_IRQEN];
        end
    end
`endif

endmodule

// File: tb/tb_mm_timer_peripheral.sv
// tb_mm_timer_peripheral: directed bus sequences against the timer
// peripheral with PRESCALE_DIV=4.
module tb_mm_timer_peripheral;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] A_CTRL   = BASE + 32'h0;
    localparam logic [31:0] A_LOAD   = BASE + 32'h4;
    localparam logic [31:0] A_COUNT  = BASE + 32'h8;
    localparam logic [31:0] A_STATUS = BASE + 32'hC;

    logic clk = 1'b0;
    logic rstN;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    MMPeripheralInterface bus();
`ifdef MMTIMER_IRQ_EN
    logic irq;
`endif

    mm_timer_peripheral #(
        .BASE_ADDR    (BASE),
        .COUNTER_WIDTH(32),
        .PRESCALE_DIV (4)
    ) dut (
        .Clock  (clk),
        .Reset_n(rstN),
        .Bus    (bus)
`ifdef MMTIMER_IRQ_EN
        ,
        .Irq    (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input string tag, input logic [31:0] addr,
                            input logic [31:0] data);
        bus.AddressBus   = addr;
        bus.DataWriteBus = data;
        bus.WriteAssert  = 1'b1;
        cyc(1);
        check({tag, ".wack"}, 32'(bus.WriteOK), 32'd1);
        bus.WriteAssert = 1'b0;
        cyc(1);
        check({tag, ".wrel"}, 32'(bus.WriteOK), 32'd0);
    endtask

    task automatic busRead(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp);
        bus.AddressBus = addr;
        bus.ReadAssert = 1'b1;
        cyc(1);
        check({tag, ".rack"}, 32'(bus.ReadOK), 32'd1);
        check({tag, ".data"}, bus.DataReadBus, exp);
        bus.ReadAssert = 1'b0;
        cyc(1);
        check({tag, ".rrel"}, 32'(bus.ReadOK), 32'd0);
        check({tag, ".dzero"}, bus.DataReadBus, 32'd0);
    endtask

    initial begin
        rstN             = 1'b0;
        bus.AddressBus   = '0;
        bus.DataWriteBus = '0;
        bus.ReadAssert   = 1'b0;
        bus.WriteAssert  = 1'b0;
        cyc(3);
        check("rst.rok", 32'(bus.ReadOK), 32'd0);
        check("rst.wok", 32'(bus.WriteOK), 32'd0);
        check("rst.rdata", bus.DataReadBus, 32'd0);
        rstN = 1'b1;
        busRead("rst.ctrl", A_CTRL, 32'd0);
        busRead("rst.load", A_LOAD, 32'd0);
        busRead("rst.count", A_COUNT, 32'd0);
        busRead("rst.status", A_STATUS, 32'd0);

        // 1: held write, ack tracks WriteAssert
        bus.AddressBus   = A_LOAD;
        bus.DataWriteBus = 32'h10;
        bus.WriteAssert  = 1'b1;
        cyc(1);
        check("t1.ack1", 32'(bus.WriteOK), 32'd1);
        cyc(1);
        check("t1.ack2", 32'(bus.WriteOK), 32'd1);
        bus.WriteAssert = 1'b0;
        cyc(1);
        check("t1.drop", 32'(bus.WriteOK), 32'd0);
        busRead("t1.count", A_COUNT, 32'h10);
        busRead("t1.load_b6", BASE + 32'h6, 32'h10);

        // 2: one-shot, tick every 4 clocks
        busWrite("t2.load", A_LOAD, 32'd3);
        busWrite("t2.ctrl", A_CTRL, 32'h1);
        cyc(3);
        busRead("t2.c2", A_COUNT, 32'd2);
        cyc(3);
        busRead("t2.c1", A_COUNT, 32'd1);
        cyc(2);
        busRead("t2.c0", A_COUNT, 32'd0);
        cyc(1);
        busRead("t2.exp", A_STATUS, 32'd1);
        busRead("t2.en0", A_CTRL, 32'd0);
        busRead("t2.hold0", A_COUNT, 32'd0);

        // 3: auto-reload and STATUS clear
        busWrite("t3.clr0", A_STATUS, 32'd1);
        busWrite("t3.load", A_LOAD, 32'd2);
        busWrite("t3.ctrl", A_CTRL, 32'h3);
        busRead("t3.st0", A_STATUS, 32'd0);
        cyc(9);
        busRead("t3.reload", A_COUNT, 32'd2);
        busRead("t3.st1", A_STATUS, 32'd1);
        busRead("t3.ctrl3", A_CTRL, 32'd3);
        busWrite("t3.stop", A_CTRL, 32'h0);
        busWrite("t3.clr", A_STATUS, 32'd1);
        busRead("t3.stclr", A_STATUS, 32'd0);
        busRead("t3.frozen", A_COUNT, 32'd1);

        // 4: unselected window, COUNT is read-only
        bus.AddressBus = BASE + 32'h20;
        bus.ReadAssert = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            check("t4.nosel.rok", 32'(bus.ReadOK), 32'd0);
            check("t4.nosel.data", bus.DataReadBus, 32'd0);
        end
        bus.ReadAssert = 1'b0;
        busWrite("t4.wcount", A_COUNT, 32'hDEAD);
        busRead("t4.count", A_COUNT, 32'd1);

        // 5a: STATUS clear on expiry edge
        busWrite("t5a.load", A_LOAD, 32'd0);
        busWrite("t5a.ctrl", A_CTRL, 32'h1);
        cyc(2);
        busWrite("t5a.clr", A_STATUS, 32'd1);
        busRead("t5a.st", A_STATUS, 32'd1);
        busRead("t5a.ctrl", A_CTRL, 32'd0);

        // 5b: CTRL write on one-shot expiry edge
        busWrite("t5b.ctrl", A_CTRL, 32'h1);
        cyc(2);
        busWrite("t5b.rewr", A_CTRL, 32'h1);
        busRead("t5b.en", A_CTRL, 32'd1);
        busWrite("t5b.stop", A_CTRL, 32'h0);
        busWrite("t5b.clr", A_STATUS, 32'd1);
        busRead("t5b.st", A_STATUS, 32'd0);

        // 5c: LOAD write on tick edge
        busWrite("t5c.load", A_LOAD, 32'd5);
        busWrite("t5c.ctrl", A_CTRL, 32'h1);
        cyc(2);
        busWrite("t5c.reload", A_LOAD, 32'd9);
        busRead("t5c.c9", A_COUNT, 32'd9);
        busWrite("t5c.stop", A_CTRL, 32'h0);
        busRead("t5c.c8", A_COUNT, 32'd8);

        // 6: reset during RD_ACK
        busWrite("t6.ctrl", A_CTRL, 32'h6);
        bus.AddressBus = A_CTRL;
        bus.ReadAssert = 1'b1;
        cyc(1);
        check("t6.rack", 32'(bus.ReadOK), 32'd1);
        check("t6.data", bus.DataReadBus, 32'd6);
        rstN = 1'b0;
        cyc(1);
        check("t6.rst.rok", 32'(bus.ReadOK), 32'd0);
        check("t6.rst.data", bus.DataReadBus, 32'd0);
        rstN = 1'b1;
        cyc(1);
        check("t6.fresh.rok", 32'(bus.ReadOK), 32'd1);
        check("t6.fresh.data", bus.DataReadBus, 32'd0);
        bus.ReadAssert = 1'b0;
        cyc(1);
        check("t6.rel", 32'(bus.ReadOK), 32'd0);

`ifdef MMTIMER_IRQ_EN
        busWrite("t6.irqctrl", A_CTRL, 32'h5);
        cyc(3);
        check("t6.irq.lag", 32'(irq), 32'd0);
        cyc(1);
        check("t6.irq", 32'(irq), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
